// File: rtl/bcd_adder_n.sv
// rtl/bcd_adder_n.sv - multi-digit BCD add/subtract, one digit per clock
// Operands are shifted right each RUN cycle; result digits enter from the top.
module bcd_adder_n #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  res;
    logic [IW-1:0] idx;
    logic          carry;
    logic          sub_reg;
    logic          bad_reg;

    logic [W-1:0]  b_cap;
    logic          bad;
    logic [4:0]    s;
    logic [3:0]    dig;
    logic          carry_next;
    logic [W-1:0]  res_next;

    // Subtraction is done as A + nines-complement(B) with inverted borrow-in.
    always_comb begin
        bad   = 1'b0;
        b_cap = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                bad = 1'b1;
            b_cap[4*i +: 4] = sub ? (4'd9 - b[4*i +: 4]) : b[4*i +: 4];
        end
    end

    always_comb begin
        s = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'd0, carry};
        if (s > 5'd9) begin
            dig        = s[3:0] + 4'd6;
            carry_next = 1'b1;
        end else begin
            dig        = s[3:0];
            carry_next = 1'b0;
        end
        res_next = (res >> 4) | (W'(dig) << (W - 4));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res     <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            sub_reg <= 1'b0;
            bad_reg <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b_cap;
                        sub_reg <= sub;
                        carry   <= sub ? ~cin : cin;
                        bad_reg <= bad;
                        res     <= '0;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> 4;
                    b_reg <= b_reg >> 4;
                    carry <= carry_next;
                    res   <= res_next;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        state <= DONE;
                        sum   <= res_next;
                        cout  <= carry_next ^ sub_reg;
                        err   <= bad_reg;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_adder_n.sv
// tb/tb_bcd_adder_n.sv - scoreboard bench for bcd_adder_n with DIGITS=4
module tb_bcd_adder_n;

    localparam int DIGITS = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    exp_t exp_q[$];
    int   ntests = 0;
    int   nfail = 0;
    int   done_count = 0;

    bcd_adder_n #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            exp_t e;
            done_count++;
            ntests++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_done: sum=%h cout=%b err=%b with no expectation", sum, cout, err);
            end else begin
                e = exp_q.pop_front();
                if (sum !== e.sum || cout !== e.cout || err !== e.err) begin
                    nfail++;
                    $display("FAIL result: got sum=%h cout=%b err=%b expected sum=%h cout=%b err=%b",
                             sum, cout, err, e.sum, e.cout, e.err);
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic tc, input logic [15:0] es, input logic ec, input logic ee);
        int busy_cycles = 0;
        int done_at = -1;
        exp_q.push_back('{sum: es, cout: ec, err: ee});
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (busy) busy_cycles++;
            if (done && done_at < 0) done_at = k;
            @(negedge clk);
        end
        check("busy_cycles", busy_cycles, 5);
        check("done_latency", done_at, 4);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int dc;
        int first_done;
        int second_done;
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout_err", {cout, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
        run_op(16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3765, 1'b0, 1'b0);
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        run_op(16'h4567, 16'h4444, 1'b0, 1'b0, 16'h9011, 1'b0, 1'b0);
        check("hold_after_done_sum", sum, 16'h9011);

        // Second start mid-RUN ignored; operand changes mid-RUN have no effect.
        dc = done_count;
        exp_q.push_back('{sum: 16'h3333, cout: 1'b0, err: 1'b0});
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_start_done_count", done_count - dc, 1);
        check("busy_start_queue", exp_q.size(), 0);
        exp_q.delete();

        // Reset after edge 2 clears outputs immediately with no done pulse.
        dc = done_count;
        @(negedge clk);
        a = 16'h2222; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_sum", sum, 0);
        check("midrst_busy_done", {busy, done}, 0);
        check("midrst_cout_err", {cout, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_done", done_count - dc, 0);
        run_op(16'h0808, 16'h0909, 1'b0, 1'b0, 16'h1717, 1'b0, 1'b0);

        // Start held high: back-to-back operations every DIGITS+2 cycles.
        first_done = -1;
        second_done = -1;
        exp_q.push_back('{sum: 16'h0246, cout: 1'b0, err: 1'b0});
        exp_q.push_back('{sum: 16'h0246, cout: 1'b0, err: 1'b0});
        @(negedge clk);
        a = 16'h0123; b = 16'h0123; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 6) start = 1'b0;
            if (done) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        check("b2b_first_done", first_done, 4);
        check("b2b_second_done", second_done, 10);
        check("b2b_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/bcd_adder_n.md
BCD_ADDER_N -- requirements
Module: bcd_adder_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits per operand; legal range 1..16.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  mode: 0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in).
REQ-006 SHALL have port a  input  4*DIGITS  operand A, digit 0 in bits [3:0].
REQ-007 SHALL have port b  input  4*DIGITS  operand B, same digit order.
REQ-008 SHALL have port cin  input  1  carry-in (add) or borrow-in (sub).
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port sum  output  4*DIGITS  registered BCD result.
REQ-012 SHALL have port cout  output  1  decimal carry-out (add) or borrow-out (sub).
REQ-013 SHALL have port err  output  1  high if any captured digit of A or B was greater than 9.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at a rising edge: SHALL capture a, b, sub and cin, clear the digit index to 0, and enter RUN.
REQ-016 On capture, SHALL set the working carry to cin when sub=0, and to NOT cin when sub=1.
REQ-017 On capture, the B operand SHALL be stored as-is when sub=0, and as its per-digit nines complement, (9 - digit) mod 16, when sub=1.
REQ-018 RUN SHALL process exactly one digit per clock, digit index i from 0 up to DIGITS-1.
REQ-019 For each digit, SHALL form the 5-bit binary sum s = A_i + B'_i + carry.
REQ-020 If s > 9, the result digit SHALL be (s + 6) mod 16 and the next carry 1; otherwise the result digit SHALL be s and the next carry 0.
REQ-021 The edge that processes digit DIGITS-1 SHALL move the FSM to DONE.
REQ-022 On that same edge, SHALL load sum with the full result, and SHALL load cout with the final carry (sub=0) or NOT the final carry (sub=1).
REQ-023 On that same edge, SHALL load err with the captured invalid-digit flag.
REQ-024 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge DIGITS and low again after edge DIGITS+1, when the FSM returns to IDLE.
REQ-025 done SHALL be high only in DONE, for exactly one cycle per operation.
REQ-026 sum, cout and err SHALL hold their values from the DONE load until the next DONE load.
REQ-027 Intermediate digits SHALL never be visible on sum.
REQ-028 start SHALL be ignored in RUN and DONE; no queuing.
REQ-029 start held continuously SHALL launch back-to-back operations, one every DIGITS+2 cycles.
REQ-030 Changes on a, b, sub or cin after capture SHALL NOT affect the operation in flight.
REQ-031 Invalid digits SHALL still be processed by the REQ-019/020 rule, giving a deterministic result, and SHALL set err.
REQ-032 All arithmetic SHALL be confined to width 4*DIGITS plus one carry bit; there is no wrap-around beyond cout.

Reset
REQ-033 rst=1 SHALL immediately, without a clock edge, force IDLE, busy=0, done=0, sum=0, cout=0, err=0, and clear the working registers and digit index.
REQ-034 Reset asserted mid-RUN SHALL abandon the operation without any done pulse.
REQ-035 After rst deasserts, the first start SHALL be accepted normally.
REQ-036 start coincident with a deasserting rst SHALL be sampled only at the first rising edge after rst is low.

Verification (DIGITS=4)
REQ-037 Add: a=0x1234, b=0x5678, sub=0, cin=0, start one cycle -> after edge 4, done=1, sum=0x6912, cout=0, err=0; busy high for 5 cycles.
REQ-038 Add carry ripple: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; same inputs with cin=1 -> sum=0x0001, cout=1.
REQ-039 Subtract: a=0x5000, b=0x1234, sub=1, cin=0 -> sum=0x3766, cout=0; a=0x0000, b=0x0001 -> sum=0x9999, cout=1 (borrow).
REQ-040 Invalid digit: a=0x00A0, b=0x0000, add -> err=1 with done; the following valid operation -> err=0.
REQ-041 Start while busy: second start pulse during RUN -> ignored, exactly one done pulse, result of the first operands only; a and b changed mid-RUN -> result unaffected.
REQ-042 Reset mid-RUN: rst pulsed after edge 2 -> outputs 0 immediately, no done pulse; a new start then yields a correct result after 4 more edges.
